dp_bram_scoreboard: RTL and testbench

Self-checking scoreboard for the dual-port BRAM simulation environment. Sits downstream of the per-port pattern generator and beside the BRAM under test. It snoops the same port control stream the RAM receives, keeps a byte-lane shadow model of the array, and predicts each read word through a latency pipeline. It compares the prediction against the RAM's read data, counts mismatches, captures the first failure and reports pass/fail when the stimulus signals end of test.

---
 rtl/dp_bram_scoreboard.sv | 209 ++++++++++++++++++++
 tb/tb_dp_bram_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_bram_scoreboard.sv
// Shadow-model scoreboard for one BRAM port: predicts each read word through a latency-matched
// delay line, compares it with the RAM's read data and reports pass/fail at end of test.
module dp_bram_scoreboard #(
   parameter int unsigned           ADDR_WIDTH   = 10,
   parameter int unsigned           DATA_WIDTH   = 16,
   parameter int unsigned           BYTEEN_WIDTH = 8,
   parameter int unsigned           RD_LATENCY   = 1,
   parameter int unsigned           WRITE_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE    = '0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic                    i_clke,
   input  logic                    i_we,
   input  logic [BYTEEN_WIDTH-1:0] i_byteen,
   input  logic                    i_addren,
   input  logic                    i_bram_rst,
   input  logic                    i_sim_end,
   input  logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    o_busy,
   output logic [31:0]             o_chk_cnt,
   output logic [31:0]             o_err_cnt,
   output logic                    o_err_first,
   output logic [ADDR_WIDTH-1:0]   o_err_addr,
   output logic [DATA_WIDTH-1:0]   o_err_exp,
   output logic [DATA_WIDTH-1:0]   o_err_got,
   output logic                    o_done,
   output logic                    o_pass
);

   localparam int LW    = int'(DATA_WIDTH / BYTEEN_WIDTH);
   localparam int NLANE = int'(BYTEEN_WIDTH);
   localparam int NLAT  = int'(RD_LATENCY);

   typedef enum logic [1:0] {StInit, StRun, StDone} state_e;

   state_e                                r_state;
   state_e                                w_state_next;
   logic [ADDR_WIDTH-1:0]                 r_init_cnt;
   logic [ADDR_WIDTH-1:0]                 r_latch;
   logic                                  r_ending;
   logic [DATA_WIDTH-1:0]                 r_shadow [2**ADDR_WIDTH];

   logic [RD_LATENCY-1:0]                 r_dl_vld;
   logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] r_dl_addr;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] r_dl_exp;

   logic [31:0]                           r_chk_cnt;
   logic [31:0]                           r_err_cnt;
   logic                                  r_err_first;
   logic [ADDR_WIDTH-1:0]                 r_err_addr;
   logic [DATA_WIDTH-1:0]                 r_err_exp;
   logic [DATA_WIDTH-1:0]                 r_err_got;

   logic                                  w_run;
   logic                                  w_active;
   logic                                  w_stop;
   logic                                  w_access;
   logic [ADDR_WIDTH-1:0]                 w_ea;
   logic [DATA_WIDTH-1:0]                 w_old;
   logic [DATA_WIDTH-1:0]                 w_merged;
   logic [DATA_WIDTH-1:0]                 w_exp;
   logic [RD_LATENCY-1:0]                 w_vld_next;
   logic                                  w_cmp;
   logic                                  w_mismatch;
   logic                                  w_mem_we;
   logic [ADDR_WIDTH-1:0]                 w_mem_addr;
   logic [DATA_WIDTH-1:0]                 w_mem_wdata;

   // A port access only happens in RUN with the port clock enabled; once end of test is
   // signalled the delay line keeps shifting to drain, but nothing new is accepted.
   assign w_run    = (r_state == StRun);
   assign w_active = w_run && !i_clke;
   assign w_stop   = r_ending || i_sim_end;
   assign w_access = w_active && !w_stop;

   assign w_ea  = i_addren ? i_addr : r_latch;
   assign w_old = r_shadow[w_ea];

   always_comb begin
      w_merged = w_old;
      for (int i = 0; i < NLANE; i++) begin
         if (i_byteen[i]) begin
            w_merged[i*LW +: LW] = i_wdata[i*LW +: LW];
         end
      end
   end

   always_comb begin
      if (i_bram_rst) begin
         w_exp = RST_VALUE;
      end else if (i_we && (WRITE_MODE != 0)) begin
         w_exp = w_merged;
      end else begin
         w_exp = w_old;
      end
   end

   always_comb begin
      w_vld_next = r_dl_vld;
      if (w_active) begin
         w_vld_next[0] = w_access;
         for (int i = 1; i < NLAT; i++) begin
            w_vld_next[i] = r_dl_vld[i-1];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StInit:  if (r_init_cnt == '1) w_state_next = StRun;
         StRun:   if (w_stop && (w_vld_next == '0)) w_state_next = StDone;
         StDone:  w_state_next = StDone;
         default: w_state_next = StInit;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StInit;
         r_init_cnt <= '0;
         r_latch    <= '0;
         r_ending   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == StInit) begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            r_latch    <= '0;
         end else if (w_access && i_addren) begin
            r_latch <= i_addr;
         end
         if (w_run && i_sim_end) begin
            r_ending <= 1'b1;
         end
      end
   end

   // Single shadow write port shared by the init sweep and snooped writes.
   assign w_mem_we    = !i_rst && ((r_state == StInit) || (w_access && i_we));
   assign w_mem_addr  = (r_state == StInit) ? r_init_cnt : w_ea;
   assign w_mem_wdata = (r_state == StInit) ? INIT_VALUE : w_merged;

   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_shadow[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dl_vld  <= '0;
         r_dl_addr <= '0;
         r_dl_exp  <= '0;
      end else if (w_active) begin
         r_dl_vld     <= w_vld_next;
         r_dl_addr[0] <= w_ea;
         r_dl_exp[0]  <= w_exp;
         for (int i = 1; i < NLAT; i++) begin
            r_dl_addr[i] <= r_dl_addr[i-1];
            r_dl_exp[i]  <= r_dl_exp[i-1];
         end
      end
   end

   // The head entry is compared only on cycles the RAM's output register also advances.
   assign w_cmp      = w_active && r_dl_vld[RD_LATENCY-1];
   assign w_mismatch = w_cmp && (i_rdata != r_dl_exp[RD_LATENCY-1]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chk_cnt   <= '0;
         r_err_cnt   <= '0;
         r_err_first <= 1'b0;
         r_err_addr  <= '0;
         r_err_exp   <= '0;
         r_err_got   <= '0;
      end else begin
         if (w_cmp) begin
            r_chk_cnt <= r_chk_cnt + 32'd1;
         end
         if (w_mismatch) begin
            if (r_err_cnt != '1) begin
               r_err_cnt <= r_err_cnt + 32'd1;
            end
            if (!r_err_first) begin
               r_err_first <= 1'b1;
               r_err_addr  <= r_dl_addr[RD_LATENCY-1];
               r_err_exp   <= r_dl_exp[RD_LATENCY-1];
               r_err_got   <= i_rdata;
            end
         end
      end
   end

   assign o_busy      = (r_state == StInit);
   assign o_done      = (r_state == StDone);
   assign o_pass      = o_done && (r_err_cnt == '0) && (r_chk_cnt != '0);
   assign o_chk_cnt   = r_chk_cnt;
   assign o_err_cnt   = r_err_cnt;
   assign o_err_first = r_err_first;
   assign o_err_addr  = r_err_addr;
   assign o_err_exp   = r_err_exp;
   assign o_err_got   = r_err_got;

endmodule

// File: tb/tb_dp_bram_scoreboard.sv
// Randomized bench for dp_bram_scoreboard: a behavioural BRAM model drives rdata and predicts
// the counter/capture outputs, which a monitor checks each time a compare is reported.
`timescale 1ns/1ps
module tb_dp_bram_scoreboard;

   localparam int unsigned    AW    = 10;
   localparam int unsigned    DW    = 16;
   localparam int unsigned    BW    = 8;
   localparam int unsigned    LAT   = 2;
   localparam int unsigned    WMODE = 1;
   localparam logic [DW-1:0]  INITV = 16'h0F0F;
   localparam logic [DW-1:0]  RSTV  = 16'h1234;
   localparam int unsigned    LW    = DW / BW;
   localparam int unsigned    DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          i_rst, i_clke, i_we, i_addren, i_bram_rst, i_sim_end;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata, i_rdata;
   logic [BW-1:0] i_byteen;
   logic          o_busy, o_err_first, o_done, o_pass;
   logic [31:0]   o_chk_cnt, o_err_cnt;
   logic [AW-1:0] o_err_addr;
   logic [DW-1:0] o_err_exp, o_err_got;

   always #5 clk = ~clk;

   dp_bram_scoreboard #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .BYTEEN_WIDTH(BW),
      .RD_LATENCY  (LAT),
      .WRITE_MODE  (WMODE),
      .INIT_VALUE  (INITV),
      .RST_VALUE   (RSTV)
   ) u_dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_addr     (i_addr),
      .i_wdata    (i_wdata),
      .i_clke     (i_clke),
      .i_we       (i_we),
      .i_byteen   (i_byteen),
      .i_addren   (i_addren),
      .i_bram_rst (i_bram_rst),
      .i_sim_end  (i_sim_end),
      .i_rdata    (i_rdata),
      .o_busy     (o_busy),
      .o_chk_cnt  (o_chk_cnt),
      .o_err_cnt  (o_err_cnt),
      .o_err_first(o_err_first),
      .o_err_addr (o_err_addr),
      .o_err_exp  (o_err_exp),
      .o_err_got  (o_err_got),
      .o_done     (o_done),
      .o_pass     (o_pass)
   );

   // Outstanding reads, tagged with the active-cycle index they were issued in.
   typedef struct {
      int unsigned   tag;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
      int            inj;
      logic [DW-1:0] injv;
   } pend_t;

   typedef struct {
      logic [31:0]   chk;
      logic [31:0]   err;
      logic          first;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] eexp;
      logic [DW-1:0] egot;
   } sb_t;

   pend_t         pend_q[$];
   sb_t           sb_q[$];
   logic [DW-1:0] mdl_mem [DEPTH];
   logic [AW-1:0] m_latch;
   int unsigned   m_act;
   logic          m_ending;
   logic [31:0]   m_chk, m_err;
   logic          m_first;
   logic [AW-1:0] m_eaddr;
   logic [DW-1:0] m_eexp, m_egot;

   int unsigned   n_vec = 0;
   int unsigned   n_fail = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
      end
   endtask

   logic [31:0] mon_prev = 32'd0;
   always @(negedge clk) begin
      sb_t r;
      if (o_chk_cnt != mon_prev && o_chk_cnt != 32'd0) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_unexpected: chk_cnt 0x%0h, want no compare", o_chk_cnt);
         end else begin
            r = sb_q.pop_front();
            check("sb_chk_cnt", o_chk_cnt, r.chk);
            check("sb_err_cnt", o_err_cnt, r.err);
            check("sb_err_first", o_err_first, r.first);
            check("sb_err_addr", o_err_addr, r.eaddr);
            check("sb_err_exp", o_err_exp, r.eexp);
            check("sb_err_got", o_err_got, r.egot);
         end
      end
      mon_prev = o_chk_cnt;
   end

   task automatic step(input logic clke, input logic we, input logic [AW-1:0] addr,
                       input logic addren, input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                       input logic brst, input int inj, input logic [DW-1:0] injv);
      pend_t         p;
      sb_t           s;
      logic [AW-1:0] ea;
      logic [DW-1:0] old, nw, rd;
      i_clke = clke; i_we = we; i_addr = addr; i_addren = addren; i_wdata = wdata;
      i_byteen = be; i_bram_rst = brst; i_sim_end = 1'b0;
      rd = DW'($urandom);
      if (!clke) begin
         if (pend_q.size() != 0 && pend_q[0].tag + LAT == m_act) begin
            p = pend_q.pop_front();
            rd = p.exp;
            if (p.inj == 1) rd = p.exp ^ DW'($urandom_range(1, 65535));
            else if (p.inj == 2) rd = p.injv;
            m_chk++;
            if (rd != p.exp) begin
               if (m_err != 32'hFFFF_FFFF) m_err++;
               if (!m_first) begin
                  m_first = 1'b1; m_eaddr = p.addr; m_eexp = p.exp; m_egot = rd;
               end
            end
            s.chk = m_chk; s.err = m_err; s.first = m_first;
            s.eaddr = m_eaddr; s.eexp = m_eexp; s.egot = m_egot;
            sb_q.push_back(s);
         end
         if (!m_ending) begin
            ea = addren ? addr : m_latch;
            if (addren) m_latch = addr;
            old = mdl_mem[ea];
            nw = old;
            for (int i = 0; i < int'(BW); i++) begin
               if (be[i]) nw[i*LW +: LW] = wdata[i*LW +: LW];
            end
            if (we) mdl_mem[ea] = nw;
            p.tag = m_act; p.addr = ea; p.inj = inj; p.injv = injv;
            p.exp = brst ? RSTV : ((we && WMODE != 0) ? nw : old);
            pend_q.push_back(p);
         end
         m_act++;
      end
      i_rdata = rd;
      @(posedge clk); #1;
   endtask

   task automatic read(input logic [AW-1:0] a, input int inj, input logic [DW-1:0] injv);
      step(1'b0, 1'b0, a, 1'b1, DW'($urandom), BW'($urandom), 1'b0, inj, injv);
   endtask

   task automatic rand_burst(input int n, input int amax, input int inj_mod);
      for (int k = 0; k < n; k++) begin
         step(($urandom % 4) == 0, ($urandom % 2) == 0, AW'($urandom_range(0, amax)),
              ($urandom % 4) != 0, DW'($urandom), BW'($urandom), ($urandom % 8) == 0,
              (inj_mod != 0 && ($urandom % inj_mod) == 0) ? 1 : 0, '0);
      end
   endtask

   task automatic do_reset();
      int n;
      i_rst = 1'b1; i_clke = 1'b0; i_we = 1'b1; i_sim_end = 1'b0; i_addren = 1'b1;
      i_addr = AW'($urandom); i_wdata = DW'($urandom); i_byteen = '1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("sb_drained", sb_q.size(), 0);
      check("rst_busy", o_busy, 1'b1);
      check("rst_chk_cnt", o_chk_cnt, 32'd0);
      check("rst_err_cnt", o_err_cnt, 32'd0);
      check("rst_err_first", o_err_first, 1'b0);
      check("rst_err_addr", o_err_addr, '0);
      check("rst_err_exp", o_err_exp, '0);
      check("rst_err_got", o_err_got, '0);
      check("rst_done", o_done, 1'b0);
      check("rst_pass", o_pass, 1'b0);
      i_rst = 1'b0;
      // Snooped inputs keep toggling during the sweep; they must be ignored.
      n = 0;
      do begin
         i_addr = AW'($urandom); i_wdata = DW'($urandom); i_sim_end = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end while (o_busy && n < int'(DEPTH) + 50);
      i_sim_end = 1'b0;
      check("init_cycles", n, DEPTH);
      for (int a = 0; a < int'(DEPTH); a++) mdl_mem[a] = INITV;
      pend_q.delete();
      m_latch = '0; m_act = 0; m_ending = 1'b0;
      m_chk = '0; m_err = '0; m_first = 1'b0; m_eaddr = '0; m_eexp = '0; m_egot = '0;
   endtask

   task automatic end_test();
      int guard;
      i_clke = 1'b1; i_sim_end = 1'b1; i_rdata = DW'($urandom);
      m_ending = 1'b1;
      @(posedge clk); #1;
      i_sim_end = 1'b0;
      check("done_after_strobe", o_done, pend_q.size() == 0);
      guard = 0;
      while (pend_q.size() != 0 && guard < 8) begin
         read(AW'($urandom), 0, '0);
         guard++;
         check("done_timing", o_done, pend_q.size() == 0);
      end
      check("drain_bound", pend_q.size(), 0);
      check("end_pass", o_pass, (m_err == 0) && (m_chk != 0));
   endtask

   initial begin
      i_rst = 1'b1; i_clke = 1'b1; i_we = 1'b0; i_addren = 1'b0; i_bram_rst = 1'b0;
      i_sim_end = 1'b0; i_addr = '0; i_wdata = '0; i_byteen = '0; i_rdata = '0;

      // Full readout after init.
      do_reset();
      for (int a = 0; a < int'(DEPTH); a++) read(AW'(a), 0, '0);
      end_test();
      check("readout_chk_cnt", o_chk_cnt, DEPTH);
      check("readout_err_cnt", o_err_cnt, 32'd0);
      check("readout_pass", o_pass, 1'b1);

      // Latched-address hold, byte lanes with injected error, bram_rst, clke inhibit.
      do_reset();
      step(1'b0, 1'b1, 10'd5, 1'b1, 16'hA5A5, 8'hFF, 1'b0, 0, '0);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, AW'($urandom), 1'b0, DW'($urandom), BW'($urandom), 1'b0, 0, '0);
      end
      check("hold_err_cnt", o_err_cnt, 32'd0);
      check("hold_chk_track", o_chk_cnt, m_chk);
      step(1'b0, 1'b1, 10'd3, 1'b1, 16'hFFFF, 8'hFF, 1'b0, 0, '0);
      step(1'b0, 1'b1, 10'd3, 1'b1, 16'h0000, 8'h01, 1'b0, 0, '0);
      read(10'd3, 2, 16'hFFFF);
      for (int k = 0; k < 3; k++) read(10'd9, 0, '0);
      check("lane_err_cnt", o_err_cnt, 32'd1);
      check("lane_err_first", o_err_first, 1'b1);
      check("lane_err_addr", o_err_addr, 10'd3);
      check("lane_err_exp", o_err_exp, 16'hFFFC);
      check("lane_err_got", o_err_got, 16'hFFFF);
      step(1'b0, 1'b1, 10'd7, 1'b1, 16'hBEEF, 8'hFF, 1'b0, 0, '0);
      step(1'b0, 1'b0, 10'd7, 1'b1, '0, '0, 1'b1, 0, '0);
      read(10'd7, 0, '0);
      read(10'd7, 0, '0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, AW'($urandom), 1'b1, DW'($urandom), '1, 1'b0, 0, '0);
         check("inhibit_chk_track", o_chk_cnt, m_chk);
      end
      read(10'd7, 0, '0);
      check("inhibit_chk_track", o_chk_cnt, m_chk);
      read(10'd5, 0, '0);
      check("inhibit_chk_track", o_chk_cnt, m_chk);
      rand_burst(300, 15, 16);
      end_test();

      // Mid-run reset with errors outstanding, then shadow must be back at init value.
      do_reset();
      rand_burst(100, 31, 0);
      for (int k = 0; k < 4; k++) read(AW'($urandom_range(0, 31)), 1, '0);
      for (int k = 0; k < 3; k++) read(AW'($urandom_range(0, 31)), 0, '0);
      check("pre_rst_err_cnt", o_err_cnt, 32'd4);
      do_reset();
      for (int a = 0; a < int'(DEPTH); a++) read(AW'(a), 0, '0);
      end_test();
      check("post_rst_chk_cnt", o_chk_cnt, DEPTH);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running, want finished");
      $fatal(1, "timeout");
   end

endmodule
